// File: rtl/key_debounce_2ch.sv
// key_debounce_2ch: per-channel two-flop synchroniser plus counter-based
// debounce FSM for active-low push buttons. Produces an active-high clean
// level and one-cycle registered press/release pulses.
//
// Debounce FSM (one per channel)
//   state   | meaning
//   STABLE  | synchronised key agrees with key_out, counter idle at 0
//   CONFIRM | key differs from key_out, counting consecutive agreeing samples
module key_debounce_2ch #(
  parameter int CNT_MAX = 999_999,
  parameter int CH      = 2
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic [CH-1:0] key_in,
  output logic [CH-1:0] key_out,
  output logic [CH-1:0] key_press,
  output logic [CH-1:0] key_release
);

  localparam int CW = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {
    STABLE  = 1'b0,
    CONFIRM = 1'b1
  } state_t;

  logic [CH-1:0] s1;
  logic [CH-1:0] s2;

  // Two-flop synchroniser; resets to the released (high) pin level
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= key_in;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_t        state;
    logic [CW-1:0] cnt;
    logic          level;
    logic          press;
    logic          release_p;
    logic          key_sync;

    assign key_sync = ~s2[i];

    // Debounce FSM; a commit updates the level and the matching pulse together
    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        state     <= STABLE;
        cnt       <= '0;
        level     <= 1'b0;
        press     <= 1'b0;
        release_p <= 1'b0;
      end else begin
        press     <= 1'b0;
        release_p <= 1'b0;
        case (state)
          STABLE: begin
            if (key_sync != level) begin
              state <= CONFIRM;
              cnt   <= CNT_ONE;
            end else begin
              cnt <= '0;
            end
          end
          CONFIRM: begin
            if (key_sync == level) begin
              // Bounce back: qualification restarts from zero next time
              state <= STABLE;
              cnt   <= '0;
            end else if (cnt == CNT_TOP) begin
              state     <= STABLE;
              cnt       <= '0;
              level     <= key_sync;
              press     <= key_sync;
              release_p <= ~key_sync;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= STABLE;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign key_out[i]     = level;
    assign key_press[i]   = press;
    assign key_release[i] = release_p;
  end

endmodule

// File: tb/tb_key_debounce_2ch.sv
// Directed bench for key_debounce_2ch with CNT_MAX = 4 (commit 6 edges after
// a pin change first reaches the synchroniser).
module tb_key_debounce_2ch;

  localparam int CNT_MAX = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [1:0] key_in;
  logic [1:0] key_out;
  logic [1:0] key_press;
  logic [1:0] key_release;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       rst;
    logic [1:0] kin;
    logic [1:0] eo;
    logic [1:0] ep;
    logic [1:0] er;
  } vec_t;

  vec_t vecs[$];

  key_debounce_2ch #(.CNT_MAX(CNT_MAX), .CH(2)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .key_in     (key_in),
    .key_out    (key_out),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic [1:0] kin, input logic [1:0] eo,
                     input logic [1:0] ep, input logic [1:0] er, input int n);
    vec_t v;
    v.rst = rst; v.kin = kin; v.eo = eo; v.ep = ep; v.er = er;
    repeat (n) vecs.push_back(v);
  endtask

  // Drive inputs, take one rising edge, then compare all outputs 1 time unit later
  task automatic apply(input logic rst, input logic [1:0] kin, input logic [1:0] eo,
                       input logic [1:0] ep, input logic [1:0] er, input string tag);
    sys_rst = rst;
    key_in  = kin;
    @(posedge sys_clk);
    #1;
    check({tag, "_out"}, key_out, eo);
    check({tag, "_press"}, key_press, ep);
    check({tag, "_release"}, key_release, er);
  endtask

  initial begin
    logic [10:0] bpat;
    logic        b;

    sys_rst = 1'b1;
    key_in  = 2'b11;

    // Reset with both keys held, then both qualify together
    add(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3);
    add(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 6);
    add(1'b0, 2'b00, 2'b11, 2'b11, 2'b00, 1);
    add(1'b0, 2'b00, 2'b11, 2'b00, 2'b00, 2);
    // Simultaneous release of both keys
    add(1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 6);
    add(1'b0, 2'b11, 2'b00, 2'b00, 2'b11, 1);
    add(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2);
    // Clean press on ch0 only
    add(1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 6);
    add(1'b0, 2'b10, 2'b01, 2'b01, 2'b00, 1);
    add(1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 2);
    // Clean release on ch0
    add(1'b0, 2'b11, 2'b01, 2'b00, 2'b00, 6);
    add(1'b0, 2'b11, 2'b00, 2'b00, 2'b01, 1);
    add(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].kin, vecs[i].eo, vecs[i].ep, vecs[i].er,
            $sformatf("vec%0d", i));
    end

    // Bounce on ch0: pattern 0,1,0,0,1,0,0,... (index 0 applied first).
    // Last high sample is index 4, so five consecutive pressed samples reach
    // the FSM at edges 7..11 and the commit lands on edge 11.
    bpat = 11'b000_0001_0010;
    for (int k = 0; k < 14; k++) begin
      b = (k < 11) ? bpat[k] : 1'b0;
      apply(1'b0, {1'b1, b},
            (k >= 11) ? 2'b01 : 2'b00,
            (k == 11) ? 2'b01 : 2'b00,
            2'b00, $sformatf("bounce%0d", k));
    end

    // 4-cycle low glitch on ch1 is rejected; ch0 stays pressed
    for (int k = 0; k < 12; k++) begin
      apply(1'b0, {(k < 4) ? 1'b0 : 1'b1, 1'b0}, 2'b01, 2'b00, 2'b00,
            $sformatf("glitch%0d", k));
    end

    // 5-cycle low pulse on ch1 is just long enough: press at 6, release at 11
    for (int k = 0; k < 14; k++) begin
      apply(1'b0, {(k < 5) ? 1'b0 : 1'b1, 1'b0},
            (k >= 6 && k <= 10) ? 2'b11 : 2'b01,
            (k == 6) ? 2'b10 : 2'b00,
            (k == 11) ? 2'b10 : 2'b00,
            $sformatf("pulse5_%0d", k));
    end

    // Release ch0 to set up the reset cases
    for (int k = 0; k < 8; k++) begin
      apply(1'b0, 2'b11,
            (k >= 6) ? 2'b00 : 2'b01,
            2'b00,
            (k == 6) ? 2'b01 : 2'b00,
            $sformatf("rel0_%0d", k));
    end

    // Reset at cnt=3 (edge 5) discards the count; re-qualify 6 edges later.
    // A second reset with ch0 committed clears key_out and re-fires key_press.
    for (int k = 0; k < 23; k++) begin
      apply((k == 5 || k == 14), 2'b10,
            ((k >= 12 && k <= 13) || k >= 21) ? 2'b01 : 2'b00,
            (k == 12 || k == 21) ? 2'b01 : 2'b00,
            2'b00, $sformatf("rstmid%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
